// File: rtl/anim_sequencer.sv
// anim_sequencer
// Frame-rate animation controller for the tile renderer.
//   - Divides the per-video-frame tick into the idle "wobble" phase index
//     shared by every sprite (animation_count).
//   - Sequences one move transition at a time: accepts a move from game
//     logic, steps it across MOVE_FRAMES video frames, then pulses move_done
//     and advances the walk-cycle sprite index.
//
// Ports
//   Clk              system clock
//   reset            synchronous, active-high
//   frame_tick       one-cycle pulse per video frame
//   pause            freeze request (only honoured when ANIM_PAUSE_EN is defined)
//   move_valid       game logic has a move to animate
//   move_ready       sequencer can accept a move (IDLE)
//   move_busy        move transition in progress (ARMED or MOVING)
//   move_step[3:0]   interpolation step, 0..MOVE_FRAMES-1
//   move_done        one-cycle pulse at end of transition
//   walk_frame[1:0]  walk-cycle sprite index, +1 mod 4 per completed move
//   animation_count[1:0] current wobble phase, 0..NUM_PHASES-1
//
// Build option
//   ANIM_PAUSE_EN    when defined, pause=1 masks frame_tick for both the
//                    wobble counters and the move sequencer. When undefined,
//                    pause is ignored.
//
// All outputs are registered.

module anim_sequencer #(
    parameter int FRAMES_PER_PHASE = 20,
    parameter int NUM_PHASES       = 3,
    parameter int MOVE_FRAMES      = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       pause,
    input  logic       move_valid,
    output logic       move_ready,
    output logic       move_busy,
    output logic [3:0] move_step,
    output logic       move_done,
    output logic [1:0] walk_frame,
    output logic [1:0] animation_count
);

    localparam logic [7:0] SUB_LAST   = 8'(FRAMES_PER_PHASE - 1);
    localparam logic [1:0] PHASE_LAST = 2'(NUM_PHASES - 1);
    localparam logic [3:0] STEP_LAST  = 4'(MOVE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_MOVING = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Effective frame tick seen by both counters.
    logic tick_eff;

`ifdef ANIM_PAUSE_EN
    assign tick_eff = frame_tick & ~pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign tick_eff     = frame_tick;
`endif

    // ------------------------------------------------------------------
    // Wobble phase divider
    // ------------------------------------------------------------------
    logic [7:0] sub_cnt;

    always_ff @(posedge Clk) begin
        if (reset) begin
            sub_cnt         <= 8'd0;
            animation_count <= 2'd0;
        end else if (tick_eff) begin
            if (sub_cnt == SUB_LAST) begin
                sub_cnt         <= 8'd0;
                animation_count <= (animation_count == PHASE_LAST) ? 2'd0
                                                                   : animation_count + 2'd1;
            end else begin
                sub_cnt <= sub_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Move sequencer
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_nxt;
    logic [3:0] step_nxt;
    logic [1:0] walk_nxt;

    always_comb begin
        state_nxt = state;
        step_nxt  = move_step;
        walk_nxt  = walk_frame;
        case (state)
            S_IDLE: begin
                step_nxt = 4'd0;
                if (move_valid) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                // The tick in the accept cycle was seen while still IDLE, so
                // the first tick counted here is always a fresh frame.
                step_nxt = 4'd0;
                if (tick_eff) begin
                    state_nxt = S_MOVING;
                end
            end
            S_MOVING: begin
                if (tick_eff) begin
                    if (move_step == STEP_LAST) begin
                        // Step holds at its last value through the DONE cycle;
                        // walk_frame advances together with move_done.
                        state_nxt = S_DONE;
                        walk_nxt  = walk_frame + 2'd1;
                    end else begin
                        step_nxt = move_step + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                step_nxt  = 4'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                step_nxt  = 4'd0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state register.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= S_IDLE;
            move_step  <= 4'd0;
            walk_frame <= 2'd0;
            move_ready <= 1'b1;
            move_busy  <= 1'b0;
            move_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            move_step  <= step_nxt;
            walk_frame <= walk_nxt;
            move_ready <= (state_nxt == S_IDLE);
            move_busy  <= (state_nxt == S_ARMED) || (state_nxt == S_MOVING);
            move_done  <= (state_nxt == S_DONE);
        end
    end

endmodule
